lamp_mode_ctrl: RTL and testbench

- Mode controller for the lamp/motor top level.
- Debounces the ten slide switches and resolves them into a single active mode by fixed priority.
- Sequences mode changes break-before-make: every output goes off for a gap period before the new mode is enabled.
- Drives motor PWM enables, LED enables, fade select and the 7-segment code, replacing ad-hoc switch decoding in the top level.

---
 rtl/lamp_pkg.sv | 48 ++++
 rtl/sw_debounce.sv | 54 +++++
 rtl/lamp_mode_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lamp_mode_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp/motor mode controller.
package lamp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [3:0] DISP_HYPHEN = 4'hE;

  localparam logic [3:0] MODE_NONE = 4'd0;
  localparam logic [3:0] MODE_FADE = 4'd1;
  localparam logic [3:0] MODE_ALL  = 4'd2;
  localparam logic [3:0] MODE_L3   = 4'd3;
  localparam logic [3:0] MODE_L2   = 4'd4;
  localparam logic [3:0] MODE_L1   = 4'd5;
  localparam logic [3:0] MODE_L0   = 4'd6;
  localparam logic [3:0] MODE_M3   = 4'd7;
  localparam logic [3:0] MODE_M2   = 4'd8;
  localparam logic [3:0] MODE_M1   = 4'd9;

  typedef struct packed {
    logic [2:0] motor_en;
    logic [3:0] led_on;
    logic       led_fade;
  } lamp_out_t;

  // Static output pattern for a running mode.
  function automatic lamp_out_t mode_outputs(input logic [3:0] mode);
    lamp_out_t o;
    o = '0;
    case (mode)
      MODE_M1:   o.motor_en = 3'b001;
      MODE_M2:   o.motor_en = 3'b010;
      MODE_M3:   o.motor_en = 3'b100;
      MODE_L0:   o.led_on   = 4'b0001;
      MODE_L1:   o.led_on   = 4'b0010;
      MODE_L2:   o.led_on   = 4'b0100;
      MODE_L3:   o.led_on   = 4'b1000;
      MODE_ALL:  o.led_on   = 4'hF;
      MODE_FADE: o.led_fade = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch synchroniser plus prescaled two-sample debounce, one shared tick for all bits.
module sw_debounce #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [CNT_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] agree_c;
  logic             tick_c;

  assign tick_c  = (pre_q == CNT_W'(DEB_CYCLES - 1));
  assign agree_c = ~(sync2_q ^ samp_q);

  // A bit only moves when two consecutive tick samples agree.
  always_comb begin
    pre_d  = pre_q + CNT_W'(1);
    samp_d = samp_q;
    deb_d  = deb_q;
    if (tick_c) begin
      pre_d  = '0;
      samp_d = sync2_q;
      deb_d  = (agree_c & sync2_q) | (~agree_c & deb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/lamp_mode_ctrl.sv
// Priority mode select with break-before-make GAP sequencing for lamps and motors.
// Optional LED soft-start in mode 2 when LAMP_SOFTSTART_EN is defined.
module lamp_mode_ctrl
  import lamp_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = 50000,
  parameter int unsigned GAP_CYCLES     = 25000000,
  parameter int unsigned STAGGER_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  output logic [2:0] motor_en,
  output logic [3:0] led_on,
  output logic       led_fade,
  output logic       speed_fast,
  output logic [3:0] disp_code,
  output logic       busy
);

  localparam int unsigned NUM_SW = 10;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [NUM_SW-1:0] deb_sw;
  logic [3:0]        req_c;
  logic [3:0]        stage_mask_c;

  state_e     state_q, state_d;
  logic [3:0] cur_q, cur_d;
  logic [3:0] pend_q, pend_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  lamp_out_t  out_q, out_d;
  logic [3:0] disp_q, disp_d;
  logic       busy_q, busy_d;
  logic       speed_q, speed_d;

  sw_debounce #(
    .WIDTH      (NUM_SW),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_i (sw),
    .deb_o (deb_sw)
  );

  // Highest debounced switch index among 9..1 wins.
  always_comb begin
    req_c = MODE_NONE;
    for (int i = 1; i < NUM_SW; i++) begin
      if (deb_sw[i]) req_c = 4'(i);
    end
  end

`ifdef LAMP_SOFTSTART_EN
  localparam int unsigned STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  logic [STAG_W-1:0] stag_cnt_q, stag_cnt_d;
  logic [1:0]        stage_q, stage_d;

  // Stage advances every STAGGER_CYCLES while mode 2 runs; anything else clears it.
  always_comb begin
    stag_cnt_d = '0;
    stage_d    = '0;
    if (state_q == RUN && cur_q == MODE_ALL) begin
      stag_cnt_d = stag_cnt_q + STAG_W'(1);
      stage_d    = stage_q;
      if (stag_cnt_q == STAG_W'(STAGGER_CYCLES - 1)) begin
        stag_cnt_d = '0;
        if (stage_q != 2'd3) stage_d = stage_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stag_cnt_q <= '0;
      stage_q    <= '0;
    end else begin
      stag_cnt_q <= stag_cnt_d;
      stage_q    <= stage_d;
    end
  end

  assign stage_mask_c = 4'((5'd2 << stage_q) - 5'd1);
`else
  logic unused_stagger_c;
  assign unused_stagger_c = (STAGGER_CYCLES == 0);
  assign stage_mask_c     = 4'hF;
`endif

  // Next state, and next registered outputs derived from the current state.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pend_d    = pend_q;
    gap_cnt_d = gap_cnt_q;
    out_d     = '0;
    disp_d    = DISP_HYPHEN;
    busy_d    = (state_q == GAP);
    speed_d   = deb_sw[0];

    case (state_q)
      IDLE: begin
        if (req_c != MODE_NONE) begin
          pend_d    = req_c;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (req_c != pend_q) begin
          pend_d    = req_c;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          cur_d   = pend_q;
          state_d = (pend_q != MODE_NONE) ? RUN : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      RUN: begin
        out_d  = mode_outputs(cur_q);
        if (cur_q == MODE_ALL) out_d.led_on = stage_mask_c;
        disp_d = cur_q;
        if (req_c != cur_q) begin
          pend_d    = req_c;
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= MODE_NONE;
      pend_q    <= MODE_NONE;
      gap_cnt_q <= '0;
      out_q     <= '0;
      disp_q    <= DISP_HYPHEN;
      busy_q    <= 1'b0;
      speed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pend_q    <= pend_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      speed_q   <= speed_d;
    end
  end

  assign motor_en   = out_q.motor_en;
  assign led_on     = out_q.led_on;
  assign led_fade   = out_q.led_fade;
  assign speed_fast = speed_q;
  assign disp_code  = disp_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lamp_mode_ctrl.sv
// Directed bench for lamp_mode_ctrl with DEB_CYCLES=4, GAP_CYCLES=8, STAGGER_CYCLES=4.
module tb_lamp_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sw;
  logic [2:0] motor_en;
  logic [3:0] led_on;
  logic       led_fade;
  logic       speed_fast;
  logic [3:0] disp_code;
  logic       busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;

  lamp_mode_ctrl #(
    .DEB_CYCLES     (4),
    .GAP_CYCLES     (8),
    .STAGGER_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .motor_en   (motor_en),
    .led_on     (led_on),
    .led_fade   (led_fade),
    .speed_fast (speed_fast),
    .disp_code  (disp_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // {busy, disp_code, motor_en, led_on, led_fade}
  function automatic logic [12:0] outs();
    return {busy, disp_code, motor_en, led_on, led_fade};
  endfunction

  task automatic wait_busy(input string tag, input int bound);
    int n = 0;
    while (busy !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check_val(tag, 32'(busy), 32'd1);
  endtask

  task automatic gap_len(input string tag, input int exp_len);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check_val(tag, 32'(n), 32'(exp_len));
  endtask

  task automatic watch_busy(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin
      tick();
      if (busy !== 1'b0) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    int unsigned t_tick, x;

    // Reset held with every switch on
    rst_n = 1'b0;
    sw    = 10'h3FF;
    ticks(3);
    check_val("rst_outs", 32'(outs()), 32'({1'b0, 4'hE, 3'b000, 4'b0000, 1'b0}));
    check_val("rst_speed", 32'(speed_fast), 32'd0);
    sw = 10'h000;
    tick();
    rst_n = 1'b1;
    ticks(20);
    check_val("idle_after_rst", 32'(outs()), 32'({1'b0, 4'hE, 3'b000, 4'b0000, 1'b0}));

    // Short glitch never survives two samples
    sw[5] = 1'b1;
    ticks(3);
    sw[5] = 1'b0;
    watch_busy(20, seen);
    check_val("glitch_busy", 32'(seen), 32'd0);
    check_val("glitch_disp", 32'(disp_code), 32'hE);

    // Mode 9
    sw[9] = 1'b1;
    wait_busy("m9_rise", 12);
    check_val("m9_gap_off", 32'(outs()), 32'({1'b1, 4'hE, 3'b000, 4'b0000, 1'b0}));
    gap_len("m9_gap_len", 8);
    check_val("m9_run", 32'(outs()), 32'({1'b0, 4'd9, 3'b001, 4'b0000, 1'b0}));

    // Lower priority switch ignored
    sw[2] = 1'b1;
    watch_busy(20, seen);
    check_val("m9_hold_busy", 32'(seen), 32'd0);
    check_val("m9_hold_outs", 32'(outs()), 32'({1'b0, 4'd9, 3'b001, 4'b0000, 1'b0}));

    // Drop to mode 2
    sw[9] = 1'b0;
    wait_busy("m2_rise", 12);
    check_val("m2_gap_off", 32'(outs()), 32'({1'b1, 4'hE, 3'b000, 4'b0000, 1'b0}));
    gap_len("m2_gap_len", 8);
`ifdef LAMP_SOFTSTART_EN
    check_val("m2_step0", 32'(outs()), 32'({1'b0, 4'd2, 3'b000, 4'b0001, 1'b0}));
    ticks(4);
    check_val("m2_step1", 32'(led_on), 32'h3);
    ticks(4);
    check_val("m2_step2", 32'(led_on), 32'h7);
    ticks(4);
    check_val("m2_step3", 32'(outs()), 32'({1'b0, 4'd2, 3'b000, 4'b1111, 1'b0}));
`else
    check_val("m2_run", 32'(outs()), 32'({1'b0, 4'd2, 3'b000, 4'b1111, 1'b0}));
`endif

    // Back to 9 with 6 and 4 debounced underneath; learn the tick phase
    sw[9] = 1'b1;
    sw[6] = 1'b1;
    sw[4] = 1'b1;
    wait_busy("m9b_rise", 12);
    t_tick = cyc - 2;
    gap_len("m9b_gap_len", 8);
    check_val("m9b_run", 32'(outs()), 32'({1'b0, 4'd9, 3'b001, 4'b0000, 1'b0}));

    // req goes 9->6 on tick x, then 6->4 on tick x+4 while in GAP
    x = t_tick;
    while (x < cyc + 10) x += 4;
    while (cyc < x - 7) tick();
    sw[9] = 1'b0;
    while (cyc < x - 3) tick();
    sw[6] = 1'b0;
    wait_busy("restart_rise", 20);
    check_val("restart_rise_cyc", cyc, x + 2);
    gap_len("restart_gap_len", 12);
    check_val("m4_run", 32'(outs()), 32'({1'b0, 4'd4, 3'b000, 4'b0100, 1'b0}));

    // Mode 1 and speed pass-through
    sw[4] = 1'b0;
    sw[2] = 1'b0;
    sw[1] = 1'b1;
    wait_busy("m1_rise", 12);
    gap_len("m1_gap_len", 8);
    check_val("m1_run", 32'(outs()), 32'({1'b0, 4'd1, 3'b000, 4'b0000, 1'b1}));
    sw[0] = 1'b1;
    watch_busy(16, seen);
    check_val("speed_on", 32'(speed_fast), 32'd1);
    check_val("speed_no_gap", 32'(seen), 32'd0);
    check_val("speed_mode", 32'(outs()), 32'({1'b0, 4'd1, 3'b000, 4'b0000, 1'b1}));

    // All request switches off: GAP then IDLE
    sw[1] = 1'b0;
    wait_busy("idle_rise", 12);
    gap_len("idle_gap_len", 8);
    check_val("idle_outs", 32'(outs()), 32'({1'b0, 4'hE, 3'b000, 4'b0000, 1'b0}));
    check_val("idle_speed", 32'(speed_fast), 32'd1);

    // Mode 8, then asynchronous reset mid-RUN
    sw[8] = 1'b1;
    wait_busy("m8_rise", 12);
    gap_len("m8_gap_len", 8);
    check_val("m8_run", 32'(outs()), 32'({1'b0, 4'd8, 3'b010, 4'b0000, 1'b0}));
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_rst", 32'({outs(), speed_fast}), 32'({1'b0, 4'hE, 3'b000, 4'b0000, 1'b0, 1'b0}));
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_idle", 32'(outs()), 32'({1'b0, 4'hE, 3'b000, 4'b0000, 1'b0}));
    wait_busy("m8r_rise", 14);
    gap_len("m8r_gap_len", 8);
    check_val("m8r_run", 32'(outs()), 32'({1'b0, 4'd8, 3'b010, 4'b0000, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
